// File: rtl/wishbone_pkg.sv
// -----------------------------------------------------------------------------
// wishbone_pkg
// Shared Wishbone definitions for the memory subsystem: arbiter state
// encodings, master-to-slave / slave-to-master bundle types and the default
// bus widths reused by the IMEM and DMEM interfaces.
// No ports (package).
// -----------------------------------------------------------------------------
package wishbone_pkg;

    // Default bus geometry of the unified RAM path.
    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 32;
    localparam int WB_SEL_W  = WB_DATA_W / 8;

    // Arbiter state encodings kept as plain constants so the state register
    // can stay a simple logic vector.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    // Named view of the same encodings for debug/trace tooling.
    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        OWN0 = ST_OWN0,
        OWN1 = ST_OWN1,
        ERR  = ST_ERR
    } arb_state_t;

    typedef struct packed {
        logic                 cyc;
        logic                 stb;
        logic                 we;
        logic [WB_SEL_W-1:0]  sel;
        logic [WB_ADDR_W-1:0] adr;
        logic [WB_DATA_W-1:0] dat;
    } wb_m2s_t;

    typedef struct packed {
        logic [WB_DATA_W-1:0] dat;
        logic                 ack;
        logic                 err;
    } wb_s2m_t;

    // One-hot owner encoding from a master index.
    function automatic logic [1:0] owner_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/wb_rr_pick2.sv
// -----------------------------------------------------------------------------
// wb_rr_pick2
// Combinational two-way round-robin picker. A lone requester always wins;
// on a tie the master that did not own the bus last is chosen.
// Ports:
//   req        in  2  request per master (bit n = master n)
//   last_owner in  1  index of the previous bus owner
//   grant      out 2  one-hot winner, 00 when nobody requests
// -----------------------------------------------------------------------------
module wb_rr_pick2
    import wishbone_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Tie: hand the bus to whoever did not have it last time.
            2'b11:   grant = owner_onehot(~last_owner);
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// wb_mem_arbiter
// Two-master to one-slave classic Wishbone arbiter sharing the unified RAM
// between instruction fetch (master 0) and the data memory unit (master 1).
// Round-robin arbitration with a registered grant, ownership locked for the
// whole CYC, and a watchdog that answers a stuck owner with a one-cycle ERR.
// Ports:
//   iClk, iRst                 clock, synchronous active-high reset
//   iCyc, iStb, iWe [1:0]      per-master Wishbone controls
//   iSel, iAdr, iDatW          per-master select/address/write data, master n
//                              in slice [n*W +: W]
//   oDatR                      slave read data broadcast to both masters
//   oAck, oErr [1:0]           per-master acknowledge / timeout error
//   oS_cyc, oS_stb, oS_we      slave controls
//   oS_sel, oS_adr, oS_dat     slave select/address/write data
//   iS_dat, iS_ack             slave read data and acknowledge
//   oGrant [1:0]               one-hot current owner, 00 when idle
// -----------------------------------------------------------------------------
module wb_mem_arbiter
    import wishbone_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic [1:0]                iCyc,
    input  logic [1:0]                iStb,
    input  logic [1:0]                iWe,
    input  logic [2*(DATA_W/8)-1:0]   iSel,
    input  logic [2*ADDR_W-1:0]       iAdr,
    input  logic [2*DATA_W-1:0]       iDatW,
    output logic [DATA_W-1:0]         oDatR,
    output logic [1:0]                oAck,
    output logic [1:0]                oErr,
    output logic                      oS_cyc,
    output logic                      oS_stb,
    output logic                      oS_we,
    output logic [DATA_W/8-1:0]       oS_sel,
    output logic [ADDR_W-1:0]         oS_adr,
    output logic [DATA_W-1:0]         oS_dat,
    input  logic [DATA_W-1:0]         iS_dat,
    input  logic                      iS_ack,
    output logic [1:0]                oGrant
);

    localparam int SEL_W = DATA_W / 8;

    // A zero TIMEOUT still needs a legal one-bit counter; it simply never fires.
    localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_owner_q, last_owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       req;
    logic [1:0]       pick;
    logic             own_idx;
    logic             own_cyc;
    logic             own_stb;
    logic             owning;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;

    assign req = iCyc & iStb;

    wb_rr_pick2 u_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .grant      (pick)
    );

    // The registered grant doubles as the owner index, also in ERR.
    assign own_idx = grant_q[1];
    assign own_cyc = iCyc[own_idx];
    assign own_stb = iStb[own_idx];
    assign owning  = (state_q == ST_OWN0) || (state_q == ST_OWN1);

    // Saturating increment so the counter can never wrap back to zero.
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign timeout_hit = (TIMEOUT > 0) && (cnt_inc >= TMO_LIM);

    // Next-state logic. Priority inside an ownership state is: owner release,
    // then slave ACK, then watchdog, so a release or an ACK arriving together
    // with the final watchdog tick suppresses the ERR.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick != 2'b00) begin
                    state_d      = pick[0] ? ST_OWN0 : ST_OWN1;
                    grant_d      = pick;
                    last_owner_d = pick[1];
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                    cnt_d   = '0;
                end else if (iS_ack) begin
                    cnt_d = '0;
                end else if (own_stb) begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                // Grant and last owner stay put for the single ERR cycle, then
                // the bus always returns to IDLE for fresh arbitration.
                state_d = ST_IDLE;
                grant_d = 2'b00;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
                cnt_d   = '0;
            end
        endcase
    end

    // State, grant, round-robin history and watchdog registers.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'b00;
            last_owner_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
        end
    end

    // Slave-side mux and master responses. Only the owner is ever connected;
    // IDLE and ERR present an all-zero request to the slave, which also
    // discards any ACK the slave might raise while nobody owns the bus.
    always_comb begin
        oS_cyc = 1'b0;
        oS_stb = 1'b0;
        oS_we  = 1'b0;
        oS_sel = '0;
        oS_adr = '0;
        oS_dat = '0;
        oAck   = 2'b00;
        oErr   = 2'b00;
        if (owning) begin
            oS_cyc = own_cyc;
            oS_stb = own_stb;
            oS_we  = iWe[own_idx];
            oS_sel = own_idx ? iSel[SEL_W +: SEL_W]   : iSel[0 +: SEL_W];
            oS_adr = own_idx ? iAdr[ADDR_W +: ADDR_W] : iAdr[0 +: ADDR_W];
            oS_dat = own_idx ? iDatW[DATA_W +: DATA_W] : iDatW[0 +: DATA_W];
            oAck   = own_idx ? {iS_ack, 1'b0} : {1'b0, iS_ack};
        end else if (state_q == ST_ERR) begin
            oErr = grant_q;
        end
    end

    assign oDatR  = iS_dat;
    assign oGrant = grant_q;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_mem_arbiter
// Self-checking bench for wb_mem_arbiter (TIMEOUT=4). Each master request is
// pushed into that master's expected-transaction queue when it is driven and
// popped when the arbiter acknowledges it.
// -----------------------------------------------------------------------------
module tb_wb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 4;

    logic            iClk = 1'b0;
    logic            iRst;
    logic [1:0]      iCyc, iStb, iWe;
    logic [2*SW-1:0] iSel;
    logic [2*AW-1:0] iAdr;
    logic [2*DW-1:0] iDatW;
    logic [DW-1:0]   oDatR;
    logic [1:0]      oAck, oErr;
    logic            oS_cyc, oS_stb, oS_we;
    logic [SW-1:0]   oS_sel;
    logic [AW-1:0]   oS_adr;
    logic [DW-1:0]   oS_dat;
    logic [DW-1:0]   iS_dat;
    logic            iS_ack;
    logic [1:0]      oGrant;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } txn_t;

    txn_t expQ0[$];
    txn_t expQ1[$];

    int checkCount = 0;
    int errCount   = 0;
    int lastModel;

    wb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iCyc   (iCyc),
        .iStb   (iStb),
        .iWe    (iWe),
        .iSel   (iSel),
        .iAdr   (iAdr),
        .iDatW  (iDatW),
        .oDatR  (oDatR),
        .oAck   (oAck),
        .oErr   (oErr),
        .oS_cyc (oS_cyc),
        .oS_stb (oS_stb),
        .oS_we  (oS_we),
        .oS_sel (oS_sel),
        .oS_adr (oS_adr),
        .oS_dat (oS_dat),
        .iS_dat (iS_dat),
        .iS_ack (iS_ack),
        .oGrant (oGrant)
    );

    always #5 iClk = ~iClk;

    function automatic logic [1:0] onehot(input int m);
        return (m == 1) ? 2'b10 : 2'b01;
    endfunction

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic driveMaster(input int m, input logic we, input logic [AW-1:0] adr,
                               input logic [DW-1:0] dat);
        iCyc[m]            = 1'b1;
        iStb[m]            = 1'b1;
        iWe[m]             = we;
        iSel[m*SW +: SW]   = '1;
        iAdr[m*AW +: AW]   = adr;
        iDatW[m*DW +: DW]  = dat;
    endtask

    // Drive a request and record what the slave should see when it is served.
    task automatic applyStimulus(input int m, input logic we, input logic [AW-1:0] adr,
                                 input logic [DW-1:0] dat);
        txn_t t;
        driveMaster(m, we, adr, dat);
        t.we  = we;
        t.adr = adr;
        t.dat = dat;
        if (m == 0) expQ0.push_back(t);
        else        expQ1.push_back(t);
    endtask

    task automatic releaseMaster(input int m);
        iCyc[m] = 1'b0;
        iStb[m] = 1'b0;
        iWe[m]  = 1'b0;
    endtask

    // Slave acknowledges this cycle; pop the expected transaction of master m.
    task automatic serveAck(input int m, input logic [DW-1:0] rd);
        txn_t t;
        int   depth;
        iS_ack = 1'b1;
        iS_dat = rd;
        #1;
        checkOutput("ack", oAck, onehot(m));
        checkOutput("ack_err", oErr, 2'b00);
        checkOutput("datr", oDatR, rd);
        depth = (m == 0) ? expQ0.size() : expQ1.size();
        checkOutput("sb_nonempty", (depth > 0), 1);
        if (depth > 0) begin
            t = (m == 0) ? expQ0.pop_front() : expQ1.pop_front();
            checkOutput("s_adr", oS_adr, t.adr);
            checkOutput("s_we", oS_we, t.we);
            checkOutput("s_sel", oS_sel, 4'hF);
            if (t.we) checkOutput("s_dat", oS_dat, t.dat);
        end
    endtask

    initial begin
        iRst = 1'b1;
        iCyc = '0; iStb = '0; iWe = '0;
        iSel = '0; iAdr = '0; iDatW = '0;
        iS_dat = '0; iS_ack = 1'b0;
        tick();
        tick();
        checkOutput("rst_grant", oGrant, 2'b00);
        checkOutput("rst_scyc", oS_cyc, 1'b0);
        checkOutput("rst_ack", oAck, 2'b00);
        checkOutput("rst_err", oErr, 2'b00);
        iRst = 1'b0;

        // Both masters request straight out of reset, then keep re-requesting.
        lastModel = 1;
        applyStimulus(0, 1'b1, 32'h0000_0100, 32'hA0A0_0000);
        applyStimulus(1, 1'b0, 32'h0000_0200, 32'h0);
        #1;
        for (int t = 0; t < 4; t++) begin
            int em;
            int waits;
            if (iCyc[0] && iCyc[1]) em = (lastModel == 1) ? 0 : 1;
            else if (iCyc[0])       em = 0;
            else                    em = 1;
            checkOutput("rr_idle", oGrant, 2'b00);
            tick();
            lastModel = em;
            checkOutput("rr_grant", oGrant, onehot(em));
            checkOutput("rr_scyc", oS_cyc, 1'b1);
            waits = (t == 0) ? 2 : (t % 2);
            for (int w = 0; w < waits; w++) begin
                checkOutput("rr_noack", oAck, 2'b00);
                tick();
            end
            serveAck(em, 32'hD000_0000 + t);
            tick();
            iS_ack = 1'b0;
            releaseMaster(em);
            #1;
            checkOutput("rr_hold", oGrant, onehot(em));
            checkOutput("rr_relcyc", oS_cyc, 1'b0);
            tick();
            if (t < 2) applyStimulus(em, (t % 2 == 1), 32'h0000_0300 + t * 16, 32'hB0 + t);
            #1;
        end
        checkOutput("rr_bubble", oGrant, 2'b00);
        tick();
        checkOutput("rr_stay_idle", oGrant, 2'b00);
        checkOutput("rr_sb_drained", expQ0.size() + expQ1.size(), 0);

        // Locked transfer: master1 keeps CYC over three handshakes.
        applyStimulus(1, 1'b1, 32'h0000_0400, 32'hC0);
        #1;
        tick();
        checkOutput("lk_grant", oGrant, 2'b10);
        applyStimulus(0, 1'b0, 32'h0000_0500, 32'h0);
        #1;
        for (int h = 0; h < 3; h++) begin
            checkOutput("lk_own", oGrant, 2'b10);
            checkOutput("lk_adr", oS_adr, 32'h0000_0400 + h * 4);
            serveAck(1, 32'hE000_0000 + h);
            tick();
            iS_ack  = 1'b0;
            iStb[1] = 1'b0;
            #1;
            checkOutput("lk_gap_grant", oGrant, 2'b10);
            checkOutput("lk_gap_stb", oS_stb, 1'b0);
            checkOutput("lk_gap_ack0", oAck[0], 1'b0);
            tick();
            if (h < 2) applyStimulus(1, 1'b1, 32'h0000_0404 + h * 4, 32'hC1 + h);
            else       releaseMaster(1);
            #1;
        end
        checkOutput("lk_release_hold", oGrant, 2'b10);
        checkOutput("lk_release_cyc", oS_cyc, 1'b0);
        tick();
        checkOutput("lk_bubble", oGrant, 2'b00);
        tick();
        checkOutput("lk_m0_next", oGrant, 2'b01);
        serveAck(0, 32'h5555_0000);
        tick();
        iS_ack = 1'b0;
        releaseMaster(0);
        #1;
        tick();
        checkOutput("lk_idle", oGrant, 2'b00);
        checkOutput("lk_sb_drained", expQ0.size() + expQ1.size(), 0);

        // Watchdog: master0 write that the slave never answers.
        driveMaster(0, 1'b1, 32'h0000_0600, 32'hEE);
        #1;
        tick();
        for (int c = 0; c < TMO; c++) begin
            checkOutput("wd_grant", oGrant, 2'b01);
            checkOutput("wd_noerr", oErr, 2'b00);
            checkOutput("wd_cyc", oS_cyc, 1'b1);
            tick();
        end
        checkOutput("wd_err", oErr, 2'b01);
        checkOutput("wd_err_cyc", oS_cyc, 1'b0);
        checkOutput("wd_err_stb", oS_stb, 1'b0);
        checkOutput("wd_err_grant", oGrant, 2'b01);
        checkOutput("wd_err_ack", oAck, 2'b00);
        tick();
        releaseMaster(0);
        #1;
        checkOutput("wd_idle", oGrant, 2'b00);
        checkOutput("wd_err_once", oErr, 2'b00);
        tick();

        // ACK arriving on the cycle the watchdog would fire.
        applyStimulus(0, 1'b0, 32'h0000_0700, 32'h0);
        #1;
        tick();
        for (int c = 0; c < TMO - 1; c++) begin
            checkOutput("col_noack", oAck, 2'b00);
            checkOutput("col_noerr_pre", oErr, 2'b00);
            tick();
        end
        serveAck(0, 32'h7777_0000);
        tick();
        iS_ack = 1'b0;
        #1;
        checkOutput("col_noerr", oErr, 2'b00);
        checkOutput("col_still_own", oGrant, 2'b01);
        releaseMaster(0);
        #1;
        tick();
        checkOutput("col_idle", oGrant, 2'b00);

        // Reset in the middle of a master1 transfer with the ACK arriving late.
        applyStimulus(1, 1'b0, 32'h0000_0800, 32'h0);
        #1;
        tick();
        checkOutput("mr_grant", oGrant, 2'b10);
        iRst = 1'b1;
        #1;
        tick();
        iS_ack = 1'b1;
        iS_dat = 32'h8888_0000;
        #1;
        checkOutput("mr_grant_cleared", oGrant, 2'b00);
        checkOutput("mr_scyc", oS_cyc, 1'b0);
        checkOutput("mr_late_ack", oAck, 2'b00);
        // The aborted transfer will never be acknowledged.
        expQ1.delete();
        iRst   = 1'b0;
        iS_ack = 1'b0;
        driveMaster(0, 1'b0, 32'h0000_0900, 32'h0);
        driveMaster(1, 1'b0, 32'h0000_0A00, 32'h0);
        #1;
        tick();
        checkOutput("mr_rr_after_reset", oGrant, 2'b01);
        releaseMaster(0);
        releaseMaster(1);
        tick();
        tick();
        checkOutput("end_idle", oGrant, 2'b00);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    // Safety net so a stuck run still terminates with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
